pc_update: RTL and testbench
============================

PC_UPDATE -- requirements
Module: pc_update

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000; PC value loaded on reset.
REQ-002 SHALL have parameter COUNT_W, default 32; width of both statistics counters.
REQ-003 SHALL have port Clock, input, 1; single system clock, all state updates on the rising edge.
REQ-004 SHALL have port Reset_n, input, 1; synchronous active-low reset.
REQ-005 SHALL have port Tick, input, 1; clock enable; no state changes while 0.
REQ-006 SHALL have port Jump_Taken, input, 1; OR of branch-condition and jump selects from the upstream OR stage.
REQ-007 SHALL have port Jalr, input, 1; the target is register-relative, so Target bit 0 is cleared.
REQ-008 SHALL have port Target, input, 32; jump or branch destination address.
REQ-009 SHALL have port Halt, input, 1; the current instruction is a halting ecall.
REQ-010 SHALL have port Go, input, 1; resume request from the board button.
REQ-011 SHALL have port PC, output, 32; current instruction address.
REQ-012 SHALL have port Halted, output, 1; high while in HALTED state.
REQ-013 SHALL have port Retired_Count, output, COUNT_W; number of instructions retired.
REQ-014 SHALL have port Taken_Count, output, COUNT_W; number of taken jumps or branches retired.

Function
REQ-015 SHALL implement a two-state FSM with states RUN and HALTED.
REQ-016 In RUN with Tick=1 and Halt=0, SHALL set the next PC as follows:
- Target when Jump_Taken=1, with bit 0 cleared when Jalr=1 and bits [1:0] then forced to 0.
- Otherwise PC+4, modulo 2^32, so 32'hFFFFFFFC wraps to 0.
REQ-017 In RUN with Tick=1, SHALL increment Retired_Count by 1 per cycle, including the halting instruction.
REQ-018 In RUN with Tick=1, Halt=0 and Jump_Taken=1, SHALL increment Taken_Count by 1.
REQ-019 In RUN with Tick=1 and Halt=1, SHALL hold PC, go to HALTED and ignore Jump_Taken (halt wins), and SHALL NOT increment Taken_Count.
REQ-020 In HALTED, SHALL hold PC and both counters regardless of all other inputs except Go and Reset_n.
REQ-021 In HALTED with Tick=1 and Go=1, SHALL load PC+4 and return to RUN; this resume cycle SHALL NOT count as a retirement.
REQ-022 Go in RUN SHALL be ignored.
REQ-023 Counters SHALL wrap modulo 2^COUNT_W with no saturation.
REQ-024 Outputs SHALL be registered; the latency from an input edge to the PC or counter change SHALL be 1 cycle.
REQ-025 With Tick=0, SHALL keep the state, PC and counters unchanged, including any pending Halt or Go.

Reset
REQ-026 On a rising edge with Reset_n=0, SHALL set PC=RESET_PC, state=RUN, Halted=0, Retired_Count=0 and Taken_Count=0, independent of Tick.
REQ-027 Reset asserted in any state, including HALTED or mid-jump, SHALL take priority over all other inputs.

Structure
REQ-028 SHALL place the FSM state encoding (RUN=0, HALTED=1), the constant 32'd4 and the alignment mask in a shared cpu package.
REQ-029 SHALL instantiate the two identical enable-gated wrapping counters as one sub-module, stat_counter.

Verification
REQ-030 Reset then 4 Ticks with Jump_Taken=0 -> PC=0x10, Retired_Count=4, Taken_Count=0.
REQ-031 From PC=0x20, Jump_Taken=1, Jalr=1, Target=0x103 -> PC=0x100 next cycle, Taken_Count=1.
REQ-032 From PC=0x40, Halt=1 and Jump_Taken=1 in the same cycle -> PC stays 0x40, Halted=1, Retired_Count +1, Taken_Count unchanged; 10 further Ticks leave all outputs unchanged.
REQ-033 From HALTED at PC=0x40, Go=1 -> PC=0x44, Halted=0, counters unchanged; Go held in RUN has no effect.
REQ-034 With PC=0xFFFFFFFC, Jump_Taken=0 -> PC=0x00000000; with Tick=0 for 3 cycles -> no change.
REQ-035 Reset_n=0 while HALTED with counters nonzero -> next cycle PC=RESET_PC, Halted=0, both counters 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM encoding, PC step and alignment constants for the fetch path
package cpu_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [31:0] PC_STEP    = 32'd4;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] jump_dest(input logic [31:0] target, input logic jalr);
        return (jalr ? (target & ~32'd1) : target) & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/stat_counter.sv
// stat_counter: enable-gated free-running counter that wraps modulo 2^W
module stat_counter #(
    parameter int W = 32
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // clear on reset, otherwise bump by one whenever enabled
    always_ff @(posedge Clock)
        if (!Reset_n) count <= '0;
        else if (en)  count <= count + W'(1);

endmodule

// File: rtl/pc_update.sv
// pc_update: program counter sequencing with halt/resume FSM and retirement statistics
module pc_update
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          COUNT_W  = 32
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Tick,
    input  logic               Jump_Taken,
    input  logic               Jalr,
    input  logic [31:0]        Target,
    input  logic               Halt,
    input  logic               Go,
    output logic [31:0]        PC,
    output logic               Halted,
    output logic [COUNT_W-1:0] Retired_Count,
    output logic [COUNT_W-1:0] Taken_Count
);

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic        retire_en, taken_en;

    // next state/PC: a halting instruction retires but never redirects or counts as taken
    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        retire_en = 1'b0;
        taken_en  = 1'b0;
        if (Tick) begin
            if (state == RUN) begin
                retire_en = 1'b1;
                if (Halt) begin
                    state_nxt = HALTED;
                end else begin
                    taken_en = Jump_Taken;
                    pc_nxt   = Jump_Taken ? jump_dest(Target, Jalr) : PC + PC_STEP;
                end
            end else if (Go) begin
                state_nxt = RUN;
                pc_nxt    = PC + PC_STEP;
            end
        end
    end

    // state and PC registers; reset overrides everything, including Tick
    always_ff @(posedge Clock)
        if (!Reset_n) begin
            state <= RUN;
            PC    <= RESET_PC;
        end else begin
            state <= state_nxt;
            PC    <= pc_nxt;
        end

    assign Halted = (state == HALTED);

    stat_counter #(.W(COUNT_W)) u_retired (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .en     (retire_en),
        .count  (Retired_Count)
    );

    stat_counter #(.W(COUNT_W)) u_taken (
        .Clock  (Clock),
        .Reset_n(Reset_n),
        .en     (taken_en),
        .count  (Taken_Count)
    );

endmodule

// File: tb/tb_pc_update.sv
// tb_pc_update: scoreboard bench for pc_update using a behavioural reference model
module tb_pc_update;

    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Tick = 1'b0;
    logic          Jump_Taken = 1'b0;
    logic          Jalr = 1'b0;
    logic [31:0]   Target = '0;
    logic          Halt = 1'b0;
    logic          Go = 1'b0;
    logic [31:0]   PC;
    logic          Halted;
    logic [CW-1:0] Retired_Count;
    logic [CW-1:0] Taken_Count;

    typedef struct {
        logic [31:0]   pc;
        logic          h;
        logic [CW-1:0] r;
        logic [CW-1:0] t;
    } exp_t;

    exp_t          q[$];
    int            total = 0;
    int            bad = 0;
    logic [31:0]   m_pc;
    logic          m_h;
    logic [CW-1:0] m_r, m_t;

    pc_update #(.RESET_PC(32'h0), .COUNT_W(CW)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .Tick         (Tick),
        .Jump_Taken   (Jump_Taken),
        .Jalr         (Jalr),
        .Target       (Target),
        .Halt         (Halt),
        .Go           (Go),
        .PC           (PC),
        .Halted       (Halted),
        .Retired_Count(Retired_Count),
        .Taken_Count  (Taken_Count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic rn, input logic tk, input logic jt,
                         input logic jr, input logic [31:0] tg, input logic hl, input logic g);
        exp_t e;
        Reset_n = rn; Tick = tk; Jump_Taken = jt; Jalr = jr; Target = tg; Halt = hl; Go = g;
        if (!rn) begin
            m_pc = 32'h0; m_h = 1'b0; m_r = '0; m_t = '0;
        end else if (tk) begin
            if (!m_h) begin
                m_r = m_r + 1'b1;
                if (hl) m_h = 1'b1;
                else if (jt) begin
                    m_t  = m_t + 1'b1;
                    m_pc = {tg[31:2], 2'b00};
                end else m_pc = m_pc + 32'd4;
            end else if (g) begin
                m_h  = 1'b0;
                m_pc = m_pc + 32'd4;
            end
        end
        q.push_back('{m_pc, m_h, m_r, m_t});
        @(posedge Clock);
        #1;
        e = q.pop_front();
        check({tag, "_pc"}, PC, e.pc);
        check({tag, "_halted"}, 32'(Halted), 32'(e.h));
        check({tag, "_retired"}, 32'(Retired_Count), 32'(e.r));
        check({tag, "_taken"}, 32'(Taken_Count), 32'(e.t));
    endtask

    initial begin
        m_pc = '0; m_h = 1'b0; m_r = '0; m_t = '0;
        #2;
        cycle("reset", 0, 0, 1, 0, 32'h55, 1, 1);
        for (int i = 0; i < 4; i++) cycle("seq", 1, 1, 0, 0, 32'h0, 0, 0);
        check("req030_pc", PC, 32'h10);
        check("req030_ret", 32'(Retired_Count), 32'd4);
        check("req030_taken", 32'(Taken_Count), 32'd0);
        for (int i = 0; i < 4; i++) cycle("seq2", 1, 1, 0, 0, 32'h0, 0, 1);
        cycle("jalr", 1, 1, 1, 1, 32'h103, 0, 0);
        check("req031_pc", PC, 32'h100);
        check("req031_taken", 32'(Taken_Count), 32'd1);
        cycle("jmp40", 1, 1, 1, 0, 32'h42, 0, 0);
        cycle("halt_jump", 1, 1, 1, 0, 32'h200, 1, 0);
        check("req032_pc", PC, 32'h40);
        check("req032_halted", 32'(Halted), 32'd1);
        for (int i = 0; i < 10; i++)
            cycle("halted_idle", 1, 1, 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 0);
        cycle("go", 1, 1, 1, 0, 32'h300, 1, 1);
        check("req033_pc", PC, 32'h44);
        check("req033_halted", 32'(Halted), 32'd0);
        for (int i = 0; i < 3; i++) cycle("go_in_run", 1, 1, 0, 0, 32'h0, 0, 1);
        cycle("jmp_top", 1, 1, 1, 0, 32'hFFFF_FFFF, 0, 0);
        cycle("wrap", 1, 1, 0, 0, 32'h0, 0, 0);
        check("req034_pc", PC, 32'h0);
        for (int i = 0; i < 3; i++) cycle("no_tick", 1, 0, 1, 1, 32'h80, 1, 1);
        cycle("halt2", 1, 1, 0, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) cycle("halted_notick_go", 1, 0, 0, 0, 32'h0, 0, 1);
        cycle("reset_halted", 0, 0, 1, 0, 32'h44, 1, 1);
        check("req035_ret", 32'(Retired_Count), 32'd0);
        for (int i = 0; i < 25; i++) cycle("run_wrap", 1, 1, 1'(i % 3 == 0), 0, 32'(i * 16), 0, 0);
        for (int i = 0; i < 150; i++)
            cycle("random", 1'($urandom_range(0, 24) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 7) == 0),
                  1'($urandom_range(0, 2) == 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
